// File: rtl/parity_frame_tx_ctrl_if.sv
// Byte-in / serial-out bundle for the parity frame transmitter.
// Handshake: a byte transfers on a rising clock edge where in_valid && in_ready;
// in is only sampled on that edge, and in_valid while in_ready is low is ignored.
interface parity_frame_tx_ctrl_if;
    logic [7:0] in;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] out;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;

    // Producer side: offers bytes, observes the line and status.
    modport master (
        output in,
        output in_valid,
        input  in_ready,
        input  out,
        input  tx,
        input  busy,
        input  frames_sent
    );

    // Controller side: accepts bytes, drives the line and status.
    modport slave (
        input  in,
        input  in_valid,
        output in_ready,
        output out,
        output tx,
        output busy,
        output frames_sent
    );
endinterface

// File: rtl/parity_frame_tx_ctrl.sv
// Parity frame transmitter: accepts a byte, forms {parity, data} and shifts it
// out as start / 8 data bits LSB first / parity / stop, each bit held for
// CLKS_PER_BIT clocks. Every output comes straight from a register.
module parity_frame_tx_ctrl #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic                        clock,
    input  logic                        reset,
    parity_frame_tx_ctrl_if.slave       bus,
    output logic [2:0]                  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Last tick index of a bit period; CLKS_PER_BIT=1 makes every state one cycle.
    localparam logic [7:0] TICK_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [8:0] out_q, out_d;
    logic [7:0] frames_q, frames_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       in_ready_q, in_ready_d;

    logic       tick_last;
    logic       accept;
    logic       frame_done;
    logic       par_in;

    assign tick_last = (tick_q == TICK_MAX);

    // Parity is taken from the byte on the bus at the accepting edge only.
    assign par_in = ODD_PARITY ? ~(^bus.in) : (^bus.in);

    // State register: every piece of controller state and every output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= 8'd0;
            bit_q      <= 3'd0;
            out_q      <= 9'h000;
            frames_q   <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            out_q      <= out_d;
            frames_q   <= frames_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next state: walk the frame, spending CLKS_PER_BIT ticks in each bit state.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        accept     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    state_d = START;
                    tick_d  = 8'd0;
                    bit_d   = 3'd0;
                end
            end
            START: begin
                if (tick_last) begin
                    state_d = DATA;
                    tick_d  = 8'd0;
                    bit_d   = 3'd0;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_d = 8'd0;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            PARITY: begin
                if (tick_last) begin
                    state_d = STOP;
                    tick_d  = 8'd0;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            STOP: begin
                if (tick_last) begin
                    state_d    = IDLE;
                    tick_d     = 8'd0;
                    frame_done = 1'b1;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = 8'd0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state so they register cleanly.
    always_comb begin
        out_d      = accept ? {par_in, bus.in} : out_q;
        frames_d   = frame_done ? (frames_q + 8'd1) : frames_q;
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = out_d[bit_d];
            PARITY:  tx_d = out_d[8];
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out         = out_q;
    assign bus.tx          = tx_q;
    assign bus.busy        = busy_q;
    assign bus.frames_sent = frames_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_parity_frame_tx_ctrl.sv
// Bench for parity_frame_tx_ctrl: two instances (2 clocks/bit even parity,
// 1 clock/bit odd parity) checked every cycle against a frame-position model.
module tb_parity_frame_tx_ctrl;

    localparam int CPB_A = 2;
    localparam bit ODD_A = 1'b0;
    localparam int CPB_B = 1;
    localparam bit ODD_B = 1'b1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    parity_frame_tx_ctrl_if if_a ();
    parity_frame_tx_ctrl_if if_b ();

    logic [7:0] in_d [2];
    logic       in_v [2];
    logic       tx_w [2];
    logic       busy_w [2];
    logic       rdy_w [2];
    logic [8:0] out_w [2];
    logic [7:0] fs_w [2];
    logic [2:0] dbg_w [2];

    assign if_a.in       = in_d[0];
    assign if_a.in_valid = in_v[0];
    assign if_b.in       = in_d[1];
    assign if_b.in_valid = in_v[1];
    assign tx_w[0] = if_a.tx;   assign tx_w[1] = if_b.tx;
    assign busy_w[0] = if_a.busy; assign busy_w[1] = if_b.busy;
    assign rdy_w[0] = if_a.in_ready; assign rdy_w[1] = if_b.in_ready;
    assign out_w[0] = if_a.out; assign out_w[1] = if_b.out;
    assign fs_w[0] = if_a.frames_sent; assign fs_w[1] = if_b.frames_sent;

    parity_frame_tx_ctrl #(.CLKS_PER_BIT(CPB_A), .ODD_PARITY(ODD_A)) u_a (
        .clock(clock), .reset(reset), .bus(if_a), .dbg_state_o(dbg_w[0])
    );
    parity_frame_tx_ctrl #(.CLKS_PER_BIT(CPB_B), .ODD_PARITY(ODD_B)) u_b (
        .clock(clock), .reset(reset), .bus(if_b), .dbg_state_o(dbg_w[1])
    );

    task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is 11 bit slots of CPB cycles each; position within the frame
    // selects the slot: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
    function automatic int cpb_of(input int k);
        return (k == 0) ? CPB_A : CPB_B;
    endfunction

    function automatic logic [8:0] encode(input int k, input logic [7:0] d);
        logic p;
        p = ^d;
        if ((k == 0) ? ODD_A : ODD_B) p = ~p;
        return {p, d};
    endfunction

    logic       m_act [2];
    int         m_pos [2];
    logic [8:0] m_word [2];
    logic [7:0] m_cnt [2];
    logic       m_done [2];
    logic [8:0] exp_q0 [$];
    logic [8:0] exp_q1 [$];

    function automatic logic model_tx(input int k);
        int slot;
        if (!m_act[k]) return 1'b1;
        slot = m_pos[k] / cpb_of(k);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_word[k][slot-1];
        if (slot == 9) return m_word[k][8];
        return 1'b1;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            m_done[k] <= 1'b0;
            if (reset) begin
                m_act[k]  <= 1'b0;
                m_pos[k]  <= 0;
                m_word[k] <= 9'h000;
                m_cnt[k]  <= 8'h00;
                if (k == 0) exp_q0.delete(); else exp_q1.delete();
            end else if (!m_act[k]) begin
                if (in_v[k]) begin
                    m_act[k]  <= 1'b1;
                    m_pos[k]  <= 0;
                    m_word[k] <= encode(k, in_d[k]);
                    if (k == 0) exp_q0.push_back(encode(k, in_d[k]));
                    else        exp_q1.push_back(encode(k, in_d[k]));
                end
            end else if (m_pos[k] == 11 * cpb_of(k) - 1) begin
                m_act[k]  <= 1'b0;
                m_cnt[k]  <= m_cnt[k] + 8'd1;
                m_done[k] <= 1'b1;
            end else begin
                m_pos[k] <= m_pos[k] + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check("tx", k, 32'(tx_w[k]), 32'(model_tx(k)));
                check("busy", k, 32'(busy_w[k]), 32'(m_act[k]));
                check("in_ready", k, 32'(rdy_w[k]), 32'(!m_act[k]));
                check("out", k, 32'(out_w[k]), 32'(m_word[k]));
                check("frames_sent", k, 32'(fs_w[k]), 32'(m_cnt[k]));
                check("dbg_idle", k, 32'(dbg_w[k] == 3'd0), 32'(!m_act[k]));
                if (m_done[k]) begin
                    if (k == 0) begin
                        if (exp_q0.size() == 0) check("exp_q_empty", k, 32'd0, 32'd1);
                        else check("frame_word", k, 32'(out_w[k]), 32'(exp_q0.pop_front()));
                    end else begin
                        if (exp_q1.size() == 0) check("exp_q_empty", k, 32'd0, 32'd1);
                        else check("frame_word", k, 32'(out_w[k]), 32'(exp_q1.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input int k, input logic [7:0] d);
        in_d[k] = d;
        in_v[k] = 1'b1;
        @(negedge clock);
        in_v[k] = 1'b0;
        in_d[k] = 8'($urandom);
    endtask

    task automatic wait_idle(input int k, output int busy_cycles);
        int guard;
        busy_cycles = 0;
        guard = 0;
        while (busy_w[k] && guard < 4000) begin
            busy_cycles++;
            guard++;
            in_d[k] = 8'($urandom);
            @(negedge clock);
        end
        check("idle_timeout", k, 32'(busy_w[k]), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        logic [8:0] exp_out;
    } vec_t;

    vec_t vecs [10];
    int   sent [2];

    initial begin
        int bc;
        int cyc;
        int last_start;
        int idle_run;
        int n;
        logic prev_busy;

        vecs[0] = '{0, 8'h00, 9'h000};
        vecs[1] = '{0, 8'h01, 9'h101};
        vecs[2] = '{0, 8'h80, 9'h180};
        vecs[3] = '{0, 8'h04, 9'h104};
        vecs[4] = '{0, 8'hFF, 9'h0FF};
        vecs[5] = '{0, 8'hA5, 9'h0A5};
        vecs[6] = '{1, 8'hFF, 9'h1FF};
        vecs[7] = '{1, 8'h00, 9'h100};
        vecs[8] = '{1, 8'h01, 9'h001};
        vecs[9] = '{1, 8'hA5, 9'h1A5};

        in_d[0] = 8'h00; in_d[1] = 8'h00;
        in_v[0] = 1'b0;  in_v[1] = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("rst_tx", k, 32'(tx_w[k]), 32'd1);
            check("rst_ready", k, 32'(rdy_w[k]), 32'd1);
            check("rst_busy", k, 32'(busy_w[k]), 32'd0);
            check("rst_out", k, 32'(out_w[k]), 32'h000);
            check("rst_frames", k, 32'(fs_w[k]), 32'h00);
        end
        reset = 1'b0;
        @(negedge clock);
        sent[0] = 0; sent[1] = 0;

        // Table-driven single frames.
        for (int i = 0; i < 10; i++) begin
            send_byte(vecs[i].k, vecs[i].d);
            check("accept_tx_low", vecs[i].k, 32'(tx_w[vecs[i].k]), 32'd0);
            wait_idle(vecs[i].k, bc);
            sent[vecs[i].k]++;
            check("vec_out", vecs[i].k, 32'(out_w[vecs[i].k]), 32'(vecs[i].exp_out));
            check("vec_busy_len", vecs[i].k, 32'(bc), 32'(11 * cpb_of(vecs[i].k)));
            check("vec_frames", vecs[i].k, 32'(fs_w[vecs[i].k]), 32'(8'(sent[vecs[i].k])));
        end

        // Reset during data bit 3 of dut0: slot 4 begins 4*CPB cycles after accept.
        send_byte(0, 8'h5A);
        repeat (4 * CPB_A) @(negedge clock);
        check("mid_bit3_busy", 0, 32'(busy_w[0]), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_tx", 0, 32'(tx_w[0]), 32'd1);
        check("mid_rst_busy", 0, 32'(busy_w[0]), 32'd0);
        check("mid_rst_ready", 0, 32'(rdy_w[0]), 32'd1);
        check("mid_rst_frames", 0, 32'(fs_w[0]), 32'h00);
        check("mid_rst_out", 0, 32'(out_w[0]), 32'h000);
        reset = 1'b0;
        @(negedge clock);
        send_byte(0, 8'h3C);
        wait_idle(0, bc);
        check("post_rst_out", 0, 32'(out_w[0]), 32'h03C);
        check("post_rst_frames", 0, 32'(fs_w[0]), 32'h01);

        // Back-to-back on dut1 with in_valid held; in scrambled while busy.
        in_v[1] = 1'b1;
        in_d[1] = 8'hA5;
        last_start = -1;
        idle_run = 0;
        prev_busy = busy_w[1];
        for (cyc = 0; cyc < 50; cyc++) begin
            @(negedge clock);
            if (busy_w[1] && !prev_busy) begin
                if (last_start >= 0) begin
                    check("b2b_interval", 1, 32'(cyc - last_start), 32'(11 * CPB_B + 1));
                    check("b2b_idle_cycles", 1, 32'(idle_run), 32'd1);
                end
                check("b2b_out", 1, 32'(out_w[1]), 32'h1A5);
                last_start = cyc;
                idle_run = 0;
            end else if (!busy_w[1]) begin
                idle_run++;
                check("b2b_idle_tx", 1, 32'(tx_w[1]), 32'd1);
            end
            prev_busy = busy_w[1];
            in_d[1] = rdy_w[1] ? 8'hA5 : 8'($urandom);
        end
        in_v[1] = 1'b0;
        wait_idle(1, bc);

        // frames_sent wrap on dut1.
        do_reset();
        in_v[1] = 1'b1;
        n = 0;
        prev_busy = busy_w[1];
        for (int c = 0; c < 256 * 12 + 200 && n < 256; c++) begin
            in_d[1] = 8'($urandom);
            @(negedge clock);
            if (prev_busy && !busy_w[1]) begin
                n++;
                if (n == 255) check("wrap_255", 1, 32'(fs_w[1]), 32'hFF);
                if (n == 256) begin
                    check("wrap_256", 1, 32'(fs_w[1]), 32'h00);
                    in_v[1] = 1'b0;
                end
            end
            prev_busy = busy_w[1];
        end
        check("wrap_frames_seen", 1, 32'(n), 32'd256);
        in_v[1] = 1'b0;
        wait_idle(1, bc);

        // Random traffic on both instances.
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 2; k++) begin
                in_v[k] = ($urandom_range(0, 2) == 0);
                in_d[k] = 8'($urandom);
            end
            @(negedge clock);
        end
        in_v[0] = 1'b0;
        in_v[1] = 1'b0;
        wait_idle(0, bc);
        wait_idle(1, bc);
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
